bus_arbiter_rr: RTL

//  Round-robin arbiter/sequencer for the 2-master / 3-slave serial system bus.
//  - Grants one master, receives its 2-bit slave select serially, then drives bus_grant/slave_sel to the bus mux.
//  - Holds the bus until trans_done; with ARB_TIMEOUT_EN, also until a watchdog expires.

---
 rtl/bus_arbiter_rr_if.sv | 24 ++
 rtl/bus_arbiter_rr.sv | 117 +++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/select/grant signals between the two masters, the arbiter and the bus mux
interface bus_arbiter_rr_if;
   logic       m1_request;
   logic       m2_request;
   logic       m1_slave_sel;
   logic       m2_slave_sel;
   logic       trans_done;
   logic       m1_grant;
   logic       m2_grant;
   logic       arbiter_busy;
   logic       bus_busy;
   logic [1:0] bus_grant;
   logic [1:0] slave_sel;
   logic       sel_error;
   logic       timeout;
   modport master (
      output m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
      input  m1_grant, m2_grant, arbiter_busy, bus_busy, bus_grant, slave_sel, sel_error, timeout
   );
   modport slave (
      input  m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
      output m1_grant, m2_grant, arbiter_busy, bus_busy, bus_grant, slave_sel, sel_error, timeout
   );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin 2-master arbiter with serial slave select; ARB_TIMEOUT_EN adds a BUSY watchdog
module bus_arbiter_rr #(
   parameter bit PRIO_INIT      = 1'b0,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TMR_W          = 11
) (
   input logic             sys_clk,
   input logic             sys_rst,
   bus_arbiter_rr_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SEL_MSB, SEL_LSB, BUSY} state_t;
   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       msb_q, msb_d;
   logic [1:0] sel_q, sel_d;
   logic       sel_error_q, sel_error_d;
   logic       timeout_q, timeout_d;
   logic       m1_grant_q, m2_grant_q, arb_busy_q, bus_busy_q;
   logic [1:0] bus_grant_q;
   logic       req_own, sel_own, expire;
   if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES >> TMR_W) != 0) begin : g_bad_cfg
      $error("bus_arbiter_rr: TIMEOUT_CYCLES must be >= 2 and below 2**TMR_W");
   end
   assign req_own = owner_q ? bus.m2_request : bus.m1_request;
   assign sel_own = owner_q ? bus.m2_slave_sel : bus.m1_slave_sel;
`ifdef ARB_TIMEOUT_EN
   logic [TMR_W-1:0] tmr_q, tmr_d;
   assign tmr_d  = (state_q == BUSY) ? tmr_q + 1'b1 : '0;
   assign expire = (state_q == BUSY) && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
   // watchdog counts BUSY cycles and sits at zero everywhere else
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) tmr_q <= '0;
      else          tmr_q <= tmr_d;
   end
`else
   assign expire = 1'b0;
`endif
   // next-state: owner is 0 for m1 / 1 for m2, last_q records who was served last
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      msb_d       = msb_q;
      sel_d       = sel_q;
      sel_error_d = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE:
            if (bus.m1_request || bus.m2_request) begin
               state_d = SEL_MSB;
               owner_d = (bus.m1_request && bus.m2_request) ? ~last_q : bus.m2_request;
            end
         SEL_MSB:
            if (!req_own) state_d = IDLE;
            else begin
               state_d = SEL_LSB;
               msb_d   = sel_own;
            end
         SEL_LSB:
            if (!req_own) state_d = IDLE;
            else if (msb_q && sel_own) begin
               state_d     = IDLE;
               sel_error_d = 1'b1;
            end else begin
               state_d = BUSY;
               sel_d   = {msb_q, sel_own};
            end
         BUSY:
            if (bus.trans_done || expire) begin
               state_d   = IDLE;
               last_d    = owner_q;
               sel_d     = 2'b00;
               timeout_d = !bus.trans_done;
            end
         default: state_d = IDLE;
      endcase
   end
   // state and registered outputs decoded from the next state
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         last_q      <= ~PRIO_INIT;
         msb_q       <= 1'b0;
         sel_q       <= 2'b00;
         sel_error_q <= 1'b0;
         timeout_q   <= 1'b0;
         m1_grant_q  <= 1'b0;
         m2_grant_q  <= 1'b0;
         arb_busy_q  <= 1'b0;
         bus_busy_q  <= 1'b0;
         bus_grant_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         msb_q       <= msb_d;
         sel_q       <= sel_d;
         sel_error_q <= sel_error_d;
         timeout_q   <= timeout_d;
         m1_grant_q  <= (state_d != IDLE) && !owner_d;
         m2_grant_q  <= (state_d != IDLE) && owner_d;
         arb_busy_q  <= (state_d == SEL_MSB) || (state_d == SEL_LSB);
         bus_busy_q  <= state_d == BUSY;
         bus_grant_q <= (state_d == BUSY) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
      end
   end
   assign bus.m1_grant     = m1_grant_q;
   assign bus.m2_grant     = m2_grant_q;
   assign bus.arbiter_busy = arb_busy_q;
   assign bus.bus_busy     = bus_busy_q;
   assign bus.bus_grant    = bus_grant_q;
   assign bus.slave_sel    = sel_q;
   assign bus.sel_error    = sel_error_q;
   assign bus.timeout      = timeout_q;
endmodule
